// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS core: controller states,
// opcode and funct fields, and ALU operation codes.
package mips_pkg;

   typedef logic [3:0] state_t;

   // Controller states; FETCH must stay at zero.
   localparam logic [3:0] FETCH   = 4'd0;
   localparam logic [3:0] DECODE  = 4'd1;
   localparam logic [3:0] MEMADR  = 4'd2;
   localparam logic [3:0] MEMRD   = 4'd3;
   localparam logic [3:0] MEMWB   = 4'd4;
   localparam logic [3:0] MEMWR   = 4'd5;
   localparam logic [3:0] RTYPEEX = 4'd6;
   localparam logic [3:0] RTYPEWB = 4'd7;
   localparam logic [3:0] BEQEX   = 4'd8;
   localparam logic [3:0] ITYPEEX = 4'd9;
   localparam logic [3:0] ITYPEWB = 4'd10;
   localparam logic [3:0] JEX     = 4'd11;

   // Opcodes, instruction bits [31:26]
   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_ORI  = 6'b001101;
   localparam logic [5:0] OP_J    = 6'b000010;

   // R-type funct field, instruction bits [5:0]
   localparam logic [5:0] FN_ADD  = 6'b100000;
   localparam logic [5:0] FN_SUB  = 6'b100010;
   localparam logic [5:0] FN_AND  = 6'b100100;
   localparam logic [5:0] FN_OR   = 6'b100101;
   localparam logic [5:0] FN_SLT  = 6'b101010;
   localparam logic [5:0] FN_SLL  = 6'b000000;
   localparam logic [5:0] FN_SRL  = 6'b000010;

   // ALU operation codes
   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SLL = 3'b011;
   localparam logic [2:0] ALU_SRL = 3'b100;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_SLT = 3'b111;

endpackage

// File: rtl/mips_aludec.sv
// R-type funct decoder: maps the funct field onto an ALU operation and
// flags functs the core does not implement.
module mips_aludec
   import mips_pkg::*;
(
   input  logic [5:0] funct,
   output logic [2:0] alucontrol,
   output logic       valid
);

   // Unknown functs decode to AND with valid low; the controller then
   // skips the register write-back.
   always_comb begin
      alucontrol = ALU_AND;
      valid      = 1'b1;
      case (funct)
         FN_ADD:  alucontrol = ALU_ADD;
         FN_SUB:  alucontrol = ALU_SUB;
         FN_AND:  alucontrol = ALU_AND;
         FN_OR:   alucontrol = ALU_OR;
         FN_SLT:  alucontrol = ALU_SLT;
         FN_SLL:  alucontrol = ALU_SLL;
         FN_SRL:  alucontrol = ALU_SRL;
         default: valid      = 1'b0;
      endcase
   end

endmodule

// File: rtl/mips_controller.sv
// Multicycle MIPS control unit: Moore FSM driving datapath selects and
// write enables from the instruction register's op/funct fields.
//
// state   | meaning
// --------+-----------------------------------------------------------
// FETCH   | read instruction at PC into IR, PC <= PC + 1
// DECODE  | branch target (PC + imm) into ALUOut, dispatch on op
// MEMADR  | effective address A + imm into ALUOut
// MEMRD   | read memory at ALUOut into MDR
// MEMWB   | write MDR to rt
// MEMWR   | write B to memory at ALUOut
// RTYPEEX | A op B according to funct
// RTYPEWB | write ALUOut to rd, ALU setup held from RTYPEEX
// BEQEX   | A - B, load PC from ALUOut when zero
// ITYPEEX | A add/or imm
// ITYPEWB | write ALUOut to rt, ALU setup held from ITYPEEX
// JEX     | load PC with jump target
module mips_controller
   import mips_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] op,
   input  logic [5:0] funct,
   output logic       alusrca,
   output logic [1:0] alusrcb,
   output logic       pcwrite,
   output logic       pcwriteCond,
   output logic [1:0] pcsource,
   output logic       memtoreg,
   output logic       regdst,
   output logic       iord,
   output logic       regwrite,
   output logic       irwrite,
   output logic       memwrite,
   output logic [2:0] alucontrol,
   output logic [3:0] state_o
);

   logic [3:0] state;
   logic [3:0] state_next;
   logic [2:0] funct_alu;
   logic       funct_ok;
   logic [2:0] itype_alu;

   mips_aludec u_aludec (
      .funct      (funct),
      .alucontrol (funct_alu),
      .valid      (funct_ok)
   );

   assign itype_alu = (op == OP_ORI) ? ALU_OR : ALU_ADD;
   assign state_o   = state;

   // State register; reset returns to FETCH on the next edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= FETCH;
      end else begin
         state <= state_next;
      end
   end

   // Next-state selection; illegal opcodes and unknown functs fall back
   // to FETCH before any architectural write.
   always_comb begin
      state_next = FETCH;
      case (state)
         FETCH:   state_next = DECODE;
         DECODE: begin
            case (op)
               OP_LW, OP_SW:     state_next = MEMADR;
               OP_R:             state_next = RTYPEEX;
               OP_BEQ:           state_next = BEQEX;
               OP_ADDI, OP_ORI:  state_next = ITYPEEX;
               OP_J:             state_next = JEX;
               default:          state_next = FETCH;
            endcase
         end
         MEMADR:  state_next = (op == OP_LW) ? MEMRD : MEMWR;
         MEMRD:   state_next = MEMWB;
         RTYPEEX: state_next = funct_ok ? RTYPEWB : FETCH;
         ITYPEEX: state_next = ITYPEWB;
         default: state_next = FETCH;
      endcase
   end

   // Output decode; during reset the FETCH setup is presented with all
   // write enables suppressed.
   always_comb begin
      alusrca     = 1'b0;
      alusrcb     = 2'b00;
      pcwrite     = 1'b0;
      pcwriteCond = 1'b0;
      pcsource    = 2'b00;
      memtoreg    = 1'b0;
      regdst      = 1'b0;
      iord        = 1'b0;
      regwrite    = 1'b0;
      irwrite     = 1'b0;
      memwrite    = 1'b0;
      alucontrol  = ALU_AND;
      case (reset ? FETCH : state)
         FETCH: begin
            irwrite    = 1'b1;
            alusrcb    = 2'b01;
            alucontrol = ALU_ADD;
            pcwrite    = 1'b1;
         end
         DECODE: begin
            alusrcb    = 2'b10;
            alucontrol = ALU_ADD;
         end
         MEMADR: begin
            alusrca    = 1'b1;
            alusrcb    = 2'b10;
            alucontrol = ALU_ADD;
         end
         MEMRD: begin
            iord = 1'b1;
         end
         MEMWB: begin
            memtoreg = 1'b1;
            regwrite = 1'b1;
         end
         MEMWR: begin
            iord     = 1'b1;
            memwrite = 1'b1;
         end
         RTYPEEX: begin
            alusrca    = 1'b1;
            alucontrol = funct_alu;
         end
         RTYPEWB: begin
            alusrca    = 1'b1;
            alucontrol = funct_alu;
            regdst     = 1'b1;
            regwrite   = 1'b1;
         end
         BEQEX: begin
            alusrca     = 1'b1;
            alucontrol  = ALU_SUB;
            pcwriteCond = 1'b1;
            pcsource    = 2'b01;
         end
         ITYPEEX: begin
            alusrca    = 1'b1;
            alusrcb    = 2'b10;
            alucontrol = itype_alu;
         end
         ITYPEWB: begin
            alusrca    = 1'b1;
            alusrcb    = 2'b10;
            alucontrol = itype_alu;
            regwrite   = 1'b1;
         end
         JEX: begin
            pcsource = 2'b10;
            pcwrite  = 1'b1;
         end
         default: begin
         end
      endcase
      if (reset) begin
         pcwrite     = 1'b0;
         pcwriteCond = 1'b0;
         irwrite     = 1'b0;
         regwrite    = 1'b0;
         memwrite    = 1'b0;
      end
   end

endmodule
